// File: rtl/mantissa_align_if.sv
// Handshake/data bundle between the exponent subtractor, the alignment
// stage and the significand adder.
//   upstream   : in_valid/in_ready, sig_a, sig_b, exp_disc, shift_spaces,
//                exp_value, out_sign
//   downstream : out_valid/out_ready, big_sig, small_sig, exp_q, sign_q,
//                swapped
// master = the surrounding pipeline (drives operands and out_ready),
// slave  = the alignment stage.
interface mantissa_align_if #(
  parameter int MANT_WIDTH = 23,
  parameter int EXP_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_WIDTH:0]   sig_a;
  logic [MANT_WIDTH:0]   sig_b;
  logic [1:0]            exp_disc;
  logic [4:0]            shift_spaces;
  logic [EXP_WIDTH-1:0]  exp_value;
  logic                  out_sign;

  logic                  out_valid;
  logic                  out_ready;
  logic [MANT_WIDTH+3:0] big_sig;
  logic [MANT_WIDTH+3:0] small_sig;
  logic [EXP_WIDTH-1:0]  exp_q;
  logic                  sign_q;
  logic                  swapped;

  modport master (
    output in_valid, sig_a, sig_b, exp_disc, shift_spaces, exp_value, out_sign,
    output out_ready,
    input  in_ready, out_valid, big_sig, small_sig, exp_q, sign_q, swapped
  );

  modport slave (
    input  in_valid, sig_a, sig_b, exp_disc, shift_spaces, exp_value, out_sign,
    input  out_ready,
    output in_ready, out_valid, big_sig, small_sig, exp_q, sign_q, swapped
  );
endinterface

// File: rtl/mantissa_align_stage.sv
// Mantissa alignment stage, downstream of the exponent subtractor.
// Picks the larger-exponent significand as big_sig and right-shifts the
// other one by shift_spaces, at most SHIFT_STEP bits per cycle, folding every
// bit shifted out into the sticky bit (small_sig[0]). Bits [2:0] of small_sig
// are guard/round/sticky; big_sig carries three zero bits in the same place.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mantissa_align_if.slave (operand in / aligned pair out handshake)
module mantissa_align_stage #(
  parameter int MANT_WIDTH = 23,
  parameter int EXP_WIDTH  = 8,
  parameter int SHIFT_STEP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mantissa_align_if.slave bus
);
  localparam int W = MANT_WIDTH + 4;
  // shift amounts never exceed 31, so a step above that behaves like 31
  localparam logic [5:0] STEP_C = (SHIFT_STEP >= 31) ? 6'd31 : SHIFT_STEP[5:0];

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [4:0]           remaining, rem_in, rem_nxt, k;
  logic [W-1:0]         big_r, small_r, small_shifted, lost_mask;
  logic [EXP_WIDTH-1:0] exp_r;
  logic                 sign_r, swapped_r;
  logic                 accept, use_b;

  assign accept = bus.in_valid & bus.in_ready;
  // 00 -> B has the larger exponent; 11 (equal) and 01 (illegal) never shift
  assign use_b  = (bus.exp_disc == 2'b00);
  assign rem_in = bus.exp_disc[0] ? 5'd0 : bus.shift_spaces;

  // per-cycle shift: k = min(remaining, step); lost bits OR into sticky
  always_comb begin
    k = remaining;
    if ({1'b0, remaining} > STEP_C) k = STEP_C[4:0];
    rem_nxt          = remaining - k;
    lost_mask        = ~({W{1'b1}} << k);
    small_shifted    = small_r >> k;
    small_shifted[0] = small_shifted[0] | (|(small_r & lost_mask));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (rem_in != 5'd0) ? SHIFT : DONE;
      SHIFT:   if (rem_nxt == 5'd0) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs; in_ready stays low while reset is held
  always_comb begin
    bus.in_ready  = rst_n && (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // datapath: loads on accept, shifts in SHIFT, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      big_r     <= '0;
      small_r   <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      swapped_r <= 1'b0;
      remaining <= '0;
    end else if (accept) begin
      big_r     <= {(use_b ? bus.sig_b : bus.sig_a), 3'b000};
      small_r   <= {(use_b ? bus.sig_a : bus.sig_b), 3'b000};
      exp_r     <= bus.exp_value;
      sign_r    <= bus.out_sign;
      swapped_r <= use_b;
      remaining <= rem_in;
    end else if (state == SHIFT) begin
      small_r   <= small_shifted;
      remaining <= rem_nxt;
    end
  end

  assign bus.big_sig   = big_r;
  assign bus.small_sig = small_r;
  assign bus.exp_q     = exp_r;
  assign bus.sign_q    = sign_r;
  assign bus.swapped   = swapped_r;
endmodule
